encoder_8x3_seq: RTL and testbench

//  Sequential 8-to-3 encoder; counterpart of the team's 3x8 one-hot decoder.
//  - Captures an 8-bit request vector. Emits the 3-bit index of every set bit, one index per output handshake, lowest bit first.
//  - Sits between status/interrupt-style bit vectors and index-driven logic, e.g. logic that feeds the 3x8 decoder.

---
 rtl/enc_pkg.sv | 18 +
 rtl/prio_enc_lsb.sv | 31 +++
 rtl/encoder_8x3_seq.sv | 131 +++++++++++++
 tb/tb_encoder_8x3_seq.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared definitions for the sequential 8-to-3 encoder: widths, FSM state
// encoding and the lowest-set-bit clear helper.
package enc_pkg;

    localparam int ENC_WIDTH = 8;
    localparam int ENC_IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    // Clears the lowest set bit of a request vector.
    function automatic logic [ENC_WIDTH-1:0] lsb_clear(input logic [ENC_WIDTH-1:0] vec);
        return vec & (vec - {{(ENC_WIDTH-1){1'b0}}, 1'b1});
    endfunction

endpackage : enc_pkg

// File: rtl/prio_enc_lsb.sv
// Combinational lowest-set-bit priority encoder. For an all-zero vector the
// index is 0 and 'any' is low.
module prio_enc_lsb #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic found_s;

    // Scan upward and latch onto the first set bit found.
    always_comb begin
        idx     = {IDX_W{1'b0}};
        found_s = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i] && !found_s) begin
                idx     = IDX_W'(i);
                found_s = 1'b1;
            end else begin
                idx     = idx;
                found_s = found_s;
            end
        end
    end

    assign any = |vec;

endmodule : prio_enc_lsb

// File: rtl/encoder_8x3_seq.sv
// Sequential 8-to-3 encoder: captures a request vector and emits the index of
// every set bit, lowest first, one per output handshake.
// Optional feature macro: ENC_LAST_EN adds the out_last port.
module encoder_8x3_seq
    import enc_pkg::*;
#(
    parameter int WIDTH = ENC_WIDTH,
    parameter int IDX_W = ENC_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [IDX_W-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             zero_vec
`ifdef ENC_LAST_EN
    ,
    output logic             out_last
`endif
);

    localparam logic [WIDTH-1:0] VEC_ZERO = {WIDTH{1'b0}};

    state_e           state_q,     state_d;
    logic [WIDTH-1:0] pending_q,   pending_d;
    logic [IDX_W-1:0] y_q,         y_d;
    logic             out_valid_q, out_valid_d;
    logic             zero_vec_q,  zero_vec_d;
    logic [IDX_W-1:0] enc_idx_s;
    logic             enc_any_s;
    logic             in_ready_s;
`ifdef ENC_LAST_EN
    logic             out_last_q,  out_last_d;
`endif

    // Capture is only possible when idle and enabled; held low while in reset.
    assign in_ready_s = en & (state_q == IDLE) & ~rst;

    // The encoder looks at the next pending value so y/out_valid can be
    // registered and still line up with the pending bits they describe.
    prio_enc_lsb #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .vec (pending_d),
        .idx (enc_idx_s),
        .any (enc_any_s)
    );

    // Next-state logic: capture in IDLE, retire one bit per accepted beat in DRAIN.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        zero_vec_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_s) begin
                    if (d != VEC_ZERO) begin
                        pending_d = d;
                        state_d   = DRAIN;
                    end else begin
                        zero_vec_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (out_valid_q && out_ready) begin
                    pending_d = lsb_clear(pending_q);
                    if (pending_d == VEC_ZERO) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DRAIN;
                    end
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d   = IDLE;
                pending_d = VEC_ZERO;
            end
        endcase
    end

    // Output values derived from the next pending vector, registered below.
    always_comb begin
        y_d         = enc_idx_s;
        out_valid_d = enc_any_s;
`ifdef ENC_LAST_EN
        out_last_d  = enc_any_s & (lsb_clear(pending_d) == VEC_ZERO);
`endif
    end

    // State and registered outputs; reset drops out_valid immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pending_q   <= VEC_ZERO;
            y_q         <= {IDX_W{1'b0}};
            out_valid_q <= 1'b0;
            zero_vec_q  <= 1'b0;
`ifdef ENC_LAST_EN
            out_last_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
            zero_vec_q  <= zero_vec_d;
`ifdef ENC_LAST_EN
            out_last_q  <= out_last_d;
`endif
        end
    end

    assign in_ready  = in_ready_s;
    assign y         = y_q;
    assign out_valid = out_valid_q;
    assign zero_vec  = zero_vec_q;
`ifdef ENC_LAST_EN
    assign out_last  = out_last_q;
`endif

endmodule : encoder_8x3_seq

// File: tb/tb_encoder_8x3_seq.sv
// Self-checking bench for encoder_8x3_seq: directed scenarios plus random
// traffic, compared against a queue-of-indices reference model.
module tb_encoder_8x3_seq;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] d;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] y;
    logic       out_valid;
    logic       out_ready;
    logic       zero_vec;
`ifdef ENC_LAST_EN
    logic       out_last;
`endif

    int n_chk;
    int n_err;
    int q[$];
    logic exp_zero;
    int beats;

    encoder_8x3_seq dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .d         (d),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .zero_vec  (zero_vec)
`ifdef ENC_LAST_EN
        ,
        .out_last  (out_last)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Check outputs against the model for the current cycle, then advance the
    // model and the clock by one cycle. Inputs were set just before the call.
    task automatic step();
        logic exp_v;
        logic exp_rdy;
        logic nz;
        int   dummy;
        #1;
        exp_rdy = en && !rst && (q.size() == 0);
        exp_v   = (q.size() != 0);
        check_eq("in_ready", {7'b0, in_ready}, {7'b0, exp_rdy});
        check_eq("out_valid", {7'b0, out_valid}, {7'b0, exp_v});
        check_eq("zero_vec", {7'b0, zero_vec}, {7'b0, exp_zero});
        if (exp_v) begin
            check_eq("y", {5'b0, y}, 8'(q[0]));
`ifdef ENC_LAST_EN
            check_eq("out_last", {7'b0, out_last}, {7'b0, (q.size() == 1)});
`endif
        end
        nz = 1'b0;
        if (exp_v && out_ready) begin
            dummy = q.pop_front();
            beats++;
        end
        if (exp_rdy && in_valid) begin
            if (d == 8'h00) begin
                nz = 1'b1;
            end else begin
                for (int i = 0; i < 8; i++) begin
                    if (d[i]) q.push_back(i);
                end
            end
        end
        exp_zero = nz;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cyc(input logic e, input logic iv, input logic [7:0] dv, input logic ordy);
        en        = e;
        in_valid  = iv;
        d         = dv;
        out_ready = ordy;
        step();
    endtask

    initial begin
        n_chk     = 0;
        n_err     = 0;
        beats     = 0;
        exp_zero  = 1'b0;
        rst       = 1'b1;
        en        = 1'b1;
        d         = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Reset state with en high
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", {7'b0, out_valid}, 8'd0);
        check_eq("rst_in_ready", {7'b0, in_ready}, 8'd0);
        check_eq("rst_zero_vec", {7'b0, zero_vec}, 8'd0);
        check_eq("rst_y", {5'b0, y}, 8'd0);
        rst = 1'b0;
        #1;
        check_eq("rel_in_ready", {7'b0, in_ready}, 8'd1);

        // Single bit
        cyc(1'b1, 1'b1, 8'b0000_0100, 1'b1);
        repeat (3) cyc(1'b1, 1'b0, 8'h00, 1'b1);

        // Multi bit
        cyc(1'b1, 1'b1, 8'b1010_0001, 1'b1);
        repeat (5) cyc(1'b1, 1'b0, 8'h00, 1'b1);

        // Backpressure with all bits set
        beats = 0;
        cyc(1'b1, 1'b1, 8'hFF, 1'b1);
        for (int k = 0; k < 40 && q.size() != 0; k++) begin
            cyc(1'b1, 1'b1, 8'h0F, (k % 2) == 1);
        end
        check_eq("ff_beats", 8'(beats), 8'd8);
        check_eq("ff_drained", 8'(q.size()), 8'd0);
        cyc(1'b1, 1'b0, 8'h00, 1'b1);

        // Zero vectors back-to-back, then en low with in_valid high
        cyc(1'b1, 1'b1, 8'h00, 1'b1);
        cyc(1'b1, 1'b1, 8'h00, 1'b1);
        cyc(1'b1, 1'b0, 8'h00, 1'b1);
        cyc(1'b0, 1'b1, 8'h55, 1'b1);
        cyc(1'b0, 1'b1, 8'h55, 1'b1);
        cyc(1'b1, 1'b0, 8'h00, 1'b1);

        // Reset in the middle of a drain
        cyc(1'b1, 1'b1, 8'h18, 1'b1);
        cyc(1'b1, 1'b0, 8'h00, 1'b1);
        rst = 1'b1;
        #1;
        check_eq("midrst_out_valid", {7'b0, out_valid}, 8'd0);
        check_eq("midrst_in_ready", {7'b0, in_ready}, 8'd0);
        q.delete();
        exp_zero = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) cyc(1'b1, 1'b0, 8'h00, 1'b1);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            logic [7:0] rv;
            rv = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1, rv,
                $urandom_range(0, 9) < 7);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule : tb_encoder_8x3_seq
